// File: rtl/beam_copper.sv
// Beam-synchronous register-write scheduler: runs a small host-loaded program once per frame and
// emits single-cycle pixel-path register writes at exact beam positions.
module beam_copper #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [9:0]    counter_h,
  input  logic [9:0]    counter_v,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [23:0]   prog_data,
  output logic          reg_we,
  output logic [3:0]    reg_addr,
  output logic [11:0]   reg_data,
  output logic          running,
  output logic [AW-1:0] pc,
  output logic          overrun
);

  typedef enum logic [1:0] {
    HALT   = 2'd0,
    FETCH  = 2'd1,
    DECODE = 2'd2,
    WAIT   = 2'd3
  } state_t;

  localparam logic [1:0]    OP_WAIT = 2'b00;
  localparam logic [1:0]    OP_MOVE = 2'b01;
  localparam logic [1:0]    OP_END  = 2'b10;
  localparam logic [AW-1:0] LAST_PC = AW'(DEPTH - 1);

  state_t        state, state_next;
  logic [AW-1:0] pc_next;
  logic          we_next;
  logic [3:0]    addr_next;
  logic [11:0]   data_next;
  logic [19:0]   target, target_next;
  logic          overrun_next;

  logic [23:0]   mem [DEPTH];
  logic [23:0]   rd_data;

  logic          frame_start;
  logic [19:0]   beam;
  state_t        adv_state;
  logic [AW-1:0] adv_pc;

  // Program RAM is never reset so the host can load it while the scheduler is held in reset.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem[prog_addr] <= prog_data;
    end
    rd_data <= mem[pc];
  end

  assign frame_start = enable && (counter_h == 10'd0) && (counter_v == 10'd0);
  assign beam        = {counter_v, counter_h};
  assign running     = (state != HALT);

  // Advancing past the last entry is an implicit END; pc parks on the last address.
  assign adv_state = (pc == LAST_PC) ? HALT : FETCH;
  assign adv_pc    = (pc == LAST_PC) ? pc : pc + AW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= HALT;
      pc       <= '0;
      reg_we   <= 1'b0;
      reg_addr <= '0;
      reg_data <= '0;
      target   <= '0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      reg_we   <= we_next;
      reg_addr <= addr_next;
      reg_data <= data_next;
      target   <= target_next;
      overrun  <= overrun_next;
    end
  end

  // Frame start outranks everything, so a MOVE decoded on the (0,0) cycle is dropped.
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    we_next      = 1'b0;
    addr_next    = reg_addr;
    data_next    = reg_data;
    target_next  = target;
    overrun_next = overrun;

    if (frame_start) begin
      state_next = FETCH;
      pc_next    = '0;
      if (state != HALT) begin
        overrun_next = 1'b1;
      end
    end else if (!enable) begin
      state_next = HALT;
    end else begin
      case (state)
        HALT: begin
          state_next = HALT;
        end
        FETCH: begin
          state_next = DECODE;
        end
        DECODE: begin
          case (rd_data[23:22])
            OP_WAIT: begin
              target_next = rd_data[19:0];
              state_next  = WAIT;
            end
            OP_MOVE: begin
              we_next    = 1'b1;
              addr_next  = rd_data[15:12];
              data_next  = rd_data[11:0];
              state_next = adv_state;
              pc_next    = adv_pc;
            end
            OP_END: begin
              state_next = HALT;
            end
            default: begin
              state_next = adv_state;
              pc_next    = adv_pc;
            end
          endcase
        end
        WAIT: begin
          if (beam >= target) begin
            state_next = adv_state;
            pc_next    = adv_pc;
          end
        end
        default: begin
          state_next = HALT;
        end
      endcase
    end
  end

endmodule
